// File: rtl/ext_irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : irq_pkg
//  Purpose  : Shared types and helpers for the external interrupt controller.
//             - irq_state_t : request/service/return state encoding
//             - onehot()    : channel id to one-hot vector (bits >= n are zero)
//  Revision : 1.0  initial release
// ============================================================================
package irq_pkg;

    // Default channel count for the ARM single-cycle core integration.
    localparam int ARM_IRQ_DEFAULT_N = 8;

    // Widest channel vector onehot() can build; NIRQ must not exceed this.
    localparam int c_IRQ_MAX_N = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // Returns a c_IRQ_MAX_N-wide vector with only bit 'id' set, or all zeros
    // when id is outside the n implemented channels.
    function automatic logic [c_IRQ_MAX_N-1:0] onehot(input int unsigned id,
                                                      input int unsigned n);
        logic [c_IRQ_MAX_N-1:0] vec;
        vec = '0;
        if (id < n) begin
            vec[id[$clog2(c_IRQ_MAX_N)-1:0]] = 1'b1;
        end
        return vec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ext_irq_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : ext_irq_ctrl_if
//  Purpose  : Bundles the peripheral IRQ lines, mask-register write port and
//             the core exception handshake of ext_irq_ctrl.
//  Ports    : irq_in, mask_we, mask_wdata, ExcAck, ERet   (master -> slave)
//             ExtIRQ, irq_id, in_service, irq_ack, mask_q (slave -> master)
//  Modports : master = core/peripheral side, slave = controller
//  Revision : 1.0  initial release
// ============================================================================
interface ext_irq_ctrl_if #(
    parameter int NIRQ = 8,
    parameter int IDW  = $clog2(NIRQ)
);
    logic [NIRQ-1:0] irq_in;
    logic            mask_we;
    logic [NIRQ-1:0] mask_wdata;
    logic            ExcAck;
    logic            ERet;
    logic            ExtIRQ;
    logic [IDW-1:0]  irq_id;
    logic            in_service;
    logic [NIRQ-1:0] irq_ack;
    logic [NIRQ-1:0] mask_q;

    modport master (
        output irq_in, mask_we, mask_wdata, ExcAck, ERet,
        input  ExtIRQ, irq_id, in_service, irq_ack, mask_q
    );

    modport slave (
        input  irq_in, mask_we, mask_wdata, ExcAck, ERet,
        output ExtIRQ, irq_id, in_service, irq_ack, mask_q
    );
endinterface
`default_nettype wire

// File: rtl/ext_irq_ctrl_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module   : irq_prio_enc
//  Purpose  : Fixed-priority encoder, lowest set index wins. Combinational.
//  Ports    : i_eligible (NIRQ) - candidate channels
//             o_any      (1)    - at least one candidate
//             o_id       (IDW)  - lowest set index (0 when none)
//  Revision : 1.0  initial release
// ============================================================================
module irq_prio_enc #(
    parameter int NIRQ = 8,
    parameter int IDW  = $clog2(NIRQ)
) (
    input  logic [NIRQ-1:0] i_eligible,
    output logic            o_any,
    output logic [IDW-1:0]  o_id
);

    // Scanning from the top down lets the lowest set index overwrite last.
    always_comb begin
        o_any = |i_eligible;
        o_id  = '0;
        for (int k = NIRQ - 1; k >= 0; k--) begin
            if (i_eligible[k]) begin
                o_id = IDW'(k);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ext_irq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ext_irq_ctrl
//  Purpose  : NIRQ-channel external interrupt controller. Each channel is
//             edge or level triggered, runtime maskable, fixed priority
//             (lowest index wins). Drives ExtIRQ into the core and runs a
//             request -> service (ExcAck) -> return (ERet) handshake.
//  Ports    : clk   - core clock
//             reset - synchronous active-high reset
//             bus   - ext_irq_ctrl_if.slave (IRQ lines, mask port, handshake)
//  Revision : 1.0  initial release
// ============================================================================
module ext_irq_ctrl
    import irq_pkg::*;
#(
    parameter int              NIRQ       = ARM_IRQ_DEFAULT_N,
    parameter int              IDW        = $clog2(NIRQ),
    parameter logic [NIRQ-1:0] LEVEL_MASK = '0,
    parameter logic [NIRQ-1:0] MASK_RST   = '1
) (
    input  logic                 clk,
    input  logic                 reset,
    ext_irq_ctrl_if.slave        bus
);

    logic [NIRQ-1:0]        r_irqSync;
    logic [NIRQ-1:0]        r_irqPrev;
    logic [NIRQ-1:0]        r_pendEdge;
    logic [NIRQ-1:0]        r_mask;
    logic [NIRQ-1:0]        w_edge;
    logic [NIRQ-1:0]        w_pending;
    logic [NIRQ-1:0]        w_eligible;
    logic                   w_any;
    logic [IDW-1:0]         w_winId;
    logic [c_IRQ_MAX_N-1:0] w_idOneHot;

    irq_state_t             r_state;
    irq_state_t             w_stateNext;
    logic                   r_extIrq;
    logic                   w_extIrqNext;
    logic [IDW-1:0]         r_irqId;
    logic [IDW-1:0]         w_irqIdNext;
    logic                   r_inService;
    logic                   w_inServiceNext;
    logic [NIRQ-1:0]        r_irqAck;
    logic [NIRQ-1:0]        w_irqAckNext;

    // ------------------------------------------------------------------
    // Input stage. Clearing r_irqPrev on reset makes a line that is held
    // high through reset look like a fresh rising edge afterwards.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqSync <= '0;
            r_irqPrev <= '0;
        end else begin
            r_irqSync <= bus.irq_in;
            r_irqPrev <= r_irqSync;
        end
    end

    assign w_edge = r_irqSync & ~r_irqPrev;

    // ------------------------------------------------------------------
    // Pending. Edge channels latch until acknowledged; the set term is
    // OR-ed after the clear so an edge in the ack cycle is not lost.
    // Level channels follow the synchronised line directly.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pendEdge <= '0;
        end else begin
            r_pendEdge <= ((r_pendEdge & ~w_irqAckNext) | w_edge) & ~LEVEL_MASK;
        end
    end

    assign w_pending  = (r_pendEdge & ~LEVEL_MASK) | (r_irqSync & LEVEL_MASK);
    assign w_eligible = w_pending & r_mask;

    // Mask register: written independently of the handshake state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mask <= MASK_RST;
        end else if (bus.mask_we) begin
            r_mask <= bus.mask_wdata;
        end
    end

    irq_prio_enc #(
        .NIRQ (NIRQ),
        .IDW  (IDW)
    ) u_prioEnc (
        .i_eligible (w_eligible),
        .o_any      (w_any),
        .o_id       (w_winId)
    );

    assign w_idOneHot = onehot(32'(r_irqId), NIRQ);

    // Only the low NIRQ bits of the helper's fixed-width result are used.
    generate
        if (NIRQ < c_IRQ_MAX_N) begin : g_ohTrim
            logic w_unusedOhHigh;
            assign w_unusedOhHigh = ^w_idOneHot[c_IRQ_MAX_N-1:NIRQ];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake FSM: state and all outputs are registered.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_extIrq    <= 1'b0;
            r_irqId     <= '0;
            r_inService <= 1'b0;
            r_irqAck    <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_extIrq    <= w_extIrqNext;
            r_irqId     <= w_irqIdNext;
            r_inService <= w_inServiceNext;
            r_irqAck    <= w_irqAckNext;
        end
    end

    always_comb begin
        w_stateNext     = r_state;
        w_extIrqNext    = r_extIrq;
        w_irqIdNext     = r_irqId;
        w_inServiceNext = r_inService;
        w_irqAckNext    = '0;

        case (r_state)
            IDLE: begin
                w_extIrqNext    = 1'b0;
                w_inServiceNext = 1'b0;
                if (w_any) begin
                    w_extIrqNext = 1'b1;
                    w_irqIdNext  = w_winId;
                    w_stateNext  = REQ;
                end
            end
            // Once raised, the request is committed: mask writes or a level
            // source dropping do not withdraw it.
            REQ: begin
                if (bus.ExcAck) begin
                    w_extIrqNext    = 1'b0;
                    w_inServiceNext = 1'b1;
                    w_irqAckNext    = w_idOneHot[NIRQ-1:0];
                    w_stateNext     = SERVICE;
                end
            end
            // No nesting: pending sources wait until ERet returns to IDLE.
            SERVICE: begin
                if (bus.ERet) begin
                    w_inServiceNext = 1'b0;
                    w_stateNext     = IDLE;
                end
            end
            default: begin
                w_extIrqNext    = 1'b0;
                w_inServiceNext = 1'b0;
                w_stateNext     = IDLE;
            end
        endcase
    end

    assign bus.ExtIRQ     = r_extIrq;
    assign bus.irq_id     = r_irqId;
    assign bus.in_service = r_inService;
    assign bus.irq_ack    = r_irqAck;
    assign bus.mask_q     = r_mask;

endmodule
`default_nettype wire

// File: doc/ext_irq_ctrl.md
Name: ext_irq_ctrl

Overview:
- Multi-channel external interrupt controller for the ARM single-cycle core. Generalises the single ExtIRQ/ExtIAck pair to NIRQ sources.
- Each channel is configurable as edge or level triggered, with a runtime mask and fixed priority (lowest index wins).
- Sits between the peripheral IRQ lines and the controller's ExtIRQ input. Uses the datapath's ExcAck and ERet to run a request/service/return handshake.
- Reports the winning channel id for the exception cause.

Parameters:
- NIRQ, 8, number of interrupt channels (>= 2).
- IDW, $clog2(NIRQ), width of irq_id.
- LEVEL_MASK, '0 (NIRQ bits), bit k=1 makes channel k level-triggered, else rising-edge.
- MASK_RST, '1 (NIRQ bits), mask register value after reset (1 = enabled).

Ports:
- clk, input, 1, core clock.
- reset, input, 1, synchronous active-high reset.
- irq_in, input, NIRQ, raw interrupt lines from peripherals.
- mask_we, input, 1, write strobe for the mask register.
- mask_wdata, input, NIRQ, new mask value.
- ExcAck, input, 1, one-cycle pulse when the core takes the exception.
- ERet, input, 1, one-cycle pulse when the core executes ERET.
- ExtIRQ, output, 1, interrupt request to the controller.
- irq_id, output, IDW, id of the requesting or in-service channel.
- in_service, output, 1, high while the handler runs.
- irq_ack, output, NIRQ, one-hot one-cycle acknowledge to the source.
- mask_q, output, NIRQ, current mask register.

Behaviour:
- Reset (synchronous, reset=1 at an edge):
  - Outputs: ExtIRQ=0, irq_id=0, in_service=0, irq_ack=0, mask_q=MASK_RST.
  - Internal: pending=0, irq_sync=0, irq_prev=0, state=IDLE.
  - Reset mid-operation drops any request or service with no ack pulse.
  - A line held high through reset is seen as a rising edge after reset.
- Input stage: irq_sync<=irq_in, irq_prev<=irq_sync. Edge on channel k is irq_sync[k]&~irq_prev[k].
- Edge channels:
  - pending[k] is set on an edge and cleared on acknowledge.
  - If a set and a clear coincide in the same cycle, the set wins; no edge is lost.
  - irq_in must stay low at least 2 cycles between edges.
- Level channels: pending[k]=irq_sync[k]. Never latched; acknowledge has no effect on it.
- Arbitration:
  - eligible = pending & mask_q.
  - Winner is the lowest set index, from combinational sub-module irq_prio_enc.
- Latency: irq_in high before edge E0 gives irq_sync=1 after E0, pending=1 after E1, and ExtIRQ=1 after E2, provided state is IDLE and the channel is unmasked.
- State machine (registered outputs):
  - IDLE: if eligible is non-zero, latch the winner into irq_id, set ExtIRQ=1, go to REQ.
  - REQ: ExtIRQ=1 and irq_id held. A mask change or deassertion of a level source does NOT withdraw the request. On ExcAck: ExtIRQ=0, in_service=1, irq_ack=onehot(irq_id) for exactly one cycle, clear pending[irq_id] if edge, go to SERVICE.
  - SERVICE: in_service=1, irq_id held, no new request (no nesting). On ERet: in_service=0, go to IDLE.
  - From IDLE, a request re-issues no earlier than one cycle after ERet.
- Ignored events: ExcAck in IDLE or SERVICE; ERet in IDLE or REQ.
- Mask register:
  - mask_we writes mask_wdata at the edge and affects arbitration from the next cycle.
  - Masked channels keep accumulating pending.
  - If mask_we and ExcAck coincide, both take effect.
- irq_id holds its last value in IDLE.

Decomposition:
- Package irq_pkg:
  - typedef enum logic [1:0] {IDLE, REQ, SERVICE} irq_state_t.
  - Function onehot(id, n).
  - localparam ARM_IRQ_DEFAULT_N = 8.
- Sub-module irq_prio_enc (parametrised NIRQ/IDW):
  - Inputs: eligible vector.
  - Outputs: any and the lowest set index.
  - Purely combinational.

Test Plan:
- Channel 5 edge: reset, irq_in=8'h20 held. ExtIRQ rises after the 3rd edge with irq_id=5. ExcAck pulse gives irq_ack=8'h20 for 1 cycle, ExtIRQ=0, in_service=1. ERet gives in_service=0 and no re-request.
- Simultaneous edges: irq_in=8'h44 in one cycle. First request has irq_id=2. After ack and ERet, irq_id=6 is requested. After the second ERet, no request.
- Masking: mask_we with 8'hFB, then ch2 edge gives no ExtIRQ for 10 cycles. Write mask 8'hFF and ExtIRQ rises 1 cycle later with irq_id=2.
- Level channel (LEVEL_MASK=8'h01):
  - ch0 held high: ack and ERet lead to re-request of id 0 one cycle after ERet.
  - ch0 dropped while in REQ: ExtIRQ stays 1 until ExcAck.
- Coincident set/clear: new ch3 edge arriving in the ExcAck cycle of ch3 leaves pending[3]=1 and re-requests id 3 after ERet.
- Reset in SERVICE: in_service=1, pulse reset. Next cycle all outputs are 0, mask_q=8'hFF, ERet is ignored, and no request is pending.
